mpp_stack_unit: RTL and testbench
=================================

# mpp_stack_unit

Parametrised hardware stack for the mpp processor core. It replaces the fixed 8-bit stack pointer counter and separate RAM with one synchronous block. The block holds stack storage, the stack pointer, full/empty status and sticky error flags. The control module drives it directly with push/pop strobes; popped data is returned on a registered output for the internal bus.

## Interface
- DATA_W, 8: width of one stack word.
- DEPTH, 256: number of entries; power of two, ≥ 2. ADDR_W = $clog2(DEPTH).
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous stack flush; highest priority after reset.
- push  input  1  push data_in this cycle.
- pop  input  1  pop top entry this cycle.
- data_in  input  DATA_W  word to push.
- data_out  output  DATA_W  registered popped word.
- data_valid  output  1  one-cycle pulse: data_out updated.
- sp  output  ADDR_W+1  current entry count (0..DEPTH); also next free address.
- empty  output  1  sp == 0.
- full  output  1  sp == DEPTH.
- overflow  output  1  sticky: push rejected while full.
- underflow  output  1  sticky: pop rejected while empty.
- high_water  output  ADDR_W+1  maximum sp since reset/clear (only with MPP_STACK_WATERMARK_EN).

## Operation
- Storage: DEPTH × DATA_W array, written synchronously. Array contents are not reset.
- sp counts entries. Push writes mem[sp]. Pop reads mem[sp-1].
- Per-cycle priority: clear, then the push/pop combination.
- clear: sp←0, overflow←0, underflow←0, high_water←0, data_valid←0. Push and pop in the same cycle are ignored.
- push only, not full: mem[sp]←data_in; sp←sp+1.
- push only, full: no write, sp unchanged, overflow←1.
- pop only, not empty: data_out←mem[sp-1]; data_valid←1; sp←sp-1.
- pop only, empty: data_out unchanged, data_valid←0, underflow←1.
- push+pop, not empty (including full): replace top. data_out←mem[sp-1] (old value), data_valid←1, mem[sp-1]←data_in, sp unchanged. No error flag.
- push+pop, empty: bypass. data_out←data_in, data_valid←1, no write, sp stays 0. No error flag.
- neither: only data_valid←0.
- overflow and underflow stay set until clear or reset. They never block later legal operations.
- Arithmetic: sp is ADDR_W+1 bits and never wraps. Full and empty are decoded from sp, not from an address compare.

## Timing
- Reset (reset_n low, asynchronous): sp=0, empty=1, full=0, data_out=0, data_valid=0, overflow=0, underflow=0, high_water=0.
- Deassertion of reset_n is synchronised outside the block. The first legal operation is on the first edge after release.
- Pop latency: data_out and data_valid are valid one clk after the edge that samples pop.
- empty, full and sp reflect the new count one clk after the sampling edge; they are combinational from the sp register.
- Back-to-back operations are legal every cycle. A push followed by a pop on the next cycle returns the just-pushed word.
- Reset mid-operation: any in-flight pop result is discarded and data_valid is forced low immediately.
- No handshake stalls: every strobe is accepted or flagged in the same cycle.

## Configuration
- MPP_STACK_WATERMARK_EN defined:
  - high_water port exists.
  - high_water←max(high_water, next sp) every edge.
  - Reset to 0 by reset_n or clear.
- MPP_STACK_WATERMARK_EN undefined:
  - high_water port and register are absent.
  - All other behaviour is identical.

## Test plan
- Reset, DATA_W=8, DEPTH=4: push 0x11,0x22,0x33,0x44 → full=1, sp=4. Fifth push 0x55 → overflow=1, sp=4. Pops return 0x44,0x33,0x22,0x11, each with a one-cycle data_valid, then empty=1.
- Pop on empty stack → underflow=1, data_valid=0, sp=0. Then clear → underflow=0.
- Push 0xA0, then push+pop with 0xB0 → data_out=0xA0, sp=1. Next pop → data_out=0xB0.
- Empty stack, push+pop with 0x5C → data_out=0x5C, data_valid=1, sp=0, no flags.
- Push 3 entries, then assert reset_n low between clock edges → sp=0 and data_valid=0 immediately, without waiting for clk. After release, pop → underflow=1.
- With MPP_STACK_WATERMARK_EN: push 3, pop 2, push 1 → high_water=3. Clear → high_water=0.

Source files
------------

// File: rtl/mpp_stack_if.sv
// Bus between the mpp control module (master) and the stack unit (slave).
// high_water exists only when MPP_STACK_WATERMARK_EN is defined.
interface mpp_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clear;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   sp;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
`ifdef MPP_STACK_WATERMARK_EN
  logic [ADDR_W:0]   high_water;
`endif

  modport master (
    output clear, push, pop, data_in,
    input  data_out, data_valid, sp, empty, full, overflow, underflow
`ifdef MPP_STACK_WATERMARK_EN
    , input high_water
`endif
  );

  modport slave (
    input  clear, push, pop, data_in,
    output data_out, data_valid, sp, empty, full, overflow, underflow
`ifdef MPP_STACK_WATERMARK_EN
    , output high_water
`endif
  );
endinterface

// File: rtl/mpp_stack_unit.sv
// Parametrised push/pop stack with entry-count pointer and sticky error flags.
// Optional high-water tracking enabled by defining MPP_STACK_WATERMARK_EN.
module mpp_stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  mpp_stack_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   sp_q, sp_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] top;
  logic              empty, full;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == (ADDR_W+1)'(DEPTH));
  // When full the low bits wrap to 0, so top still lands on DEPTH-1.
  assign top   = sp_q[ADDR_W-1:0] - ADDR_W'(1);

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    dv_d   = 1'b0;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    we     = 1'b0;
    waddr  = sp_q[ADDR_W-1:0];
    if (bus.clear) begin
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      case ({bus.push, bus.pop})
        2'b10: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            we   = 1'b1;
            sp_d = sp_q + (ADDR_W+1)'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d = mem_q[top];
            dv_d   = 1'b1;
            sp_d   = sp_q - (ADDR_W+1)'(1);
          end
        end
        2'b11: begin
          dv_d = 1'b1;
          // Empty stack: the pushed word passes straight through, nothing stored.
          if (empty) begin
            dout_d = bus.data_in;
          end else begin
            dout_d = mem_q[top];
            we     = 1'b1;
            waddr  = top;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q   <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

`ifdef MPP_STACK_WATERMARK_EN
  logic [ADDR_W:0] hw_q, hw_d;

  always_comb begin
    hw_d = hw_q;
    if (bus.clear)        hw_d = '0;
    else if (sp_d > hw_q) hw_d = sp_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hw_q <= '0;
    else          hw_q <= hw_d;
  end

  assign bus.high_water = hw_q;
`endif

  assign bus.data_out   = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.sp         = sp_q;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule

// File: tb/tb_mpp_stack_unit.sv
// Directed bench for mpp_stack_unit (DATA_W=8, DEPTH=4); popped words are
// checked by a monitor against a queue of expected values.
module tb_mpp_stack_unit;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [DATA_W-1:0] exp_q [$];

  mpp_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  mpp_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clocked operation; inputs drop back to idle 1 ns after the edge.
  task automatic cyc(input logic c, input logic ps, input logic pp, input logic [DATA_W-1:0] d);
    bus.clear = c; bus.push = ps; bus.pop = pp; bus.data_in = d;
    @(posedge clk);
    #1;
    bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic chk_state(input string nm, input int sp, input logic e, input logic f,
                           input logic ov, input logic un);
    chk({nm, ".sp"},        32'(bus.sp),    32'(sp));
    chk({nm, ".empty"},     32'(bus.empty), 32'(e));
    chk({nm, ".full"},      32'(bus.full),  32'(f));
    chk({nm, ".overflow"},  32'(bus.overflow),  32'(ov));
    chk({nm, ".underflow"}, 32'(bus.underflow), 32'(un));
  endtask

  // Monitor: every data_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && bus.data_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_valid: got data_out %0h with nothing expected", bus.data_out);
      end else begin
        chk("pop_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] pv [4];
    pv[0] = 8'h11; pv[1] = 8'h22; pv[2] = 8'h33; pv[3] = 8'h44;
    bus.clear = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;

    #12;
    chk_state("reset", 0, 1, 0, 0, 0);
    chk("reset.data_out",   32'(bus.data_out),   32'h0);
    chk("reset.data_valid", 32'(bus.data_valid), 32'h0);
    @(negedge clk); reset_n = 1'b1;

    // Fill to full, then overflow.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, pv[i]);
      chk("fill.sp", 32'(bus.sp), 32'(i + 1));
    end
    chk_state("full", 4, 0, 1, 0, 0);
    cyc(0, 1, 0, 8'h55);
    chk_state("overflow", 4, 0, 1, 1, 0);

    // Drain in LIFO order; each pop yields a single-cycle valid.
    for (int i = 3; i >= 0; i--) begin
      exp_q.push_back(pv[i]);
      cyc(0, 0, 1, 8'h00);
      chk("drain.valid", 32'(bus.data_valid), 32'h1);
    end
    cyc(0, 0, 0, 8'h00);
    chk("drain.valid_drop", 32'(bus.data_valid), 32'h0);
    chk_state("drained", 0, 1, 0, 1, 0);

    cyc(0, 0, 1, 8'h00);
    chk("underflow.valid", 32'(bus.data_valid), 32'h0);
    chk_state("underflow", 0, 1, 0, 1, 1);
    cyc(1, 1, 1, 8'h99);
    chk_state("clear", 0, 1, 0, 0, 0);
    chk("clear.valid", 32'(bus.data_valid), 32'h0);

    // Replace top, then pop the replacement.
    cyc(0, 1, 0, 8'hA0);
    exp_q.push_back(8'hA0);
    cyc(0, 1, 1, 8'hB0);
    chk_state("replace", 1, 0, 0, 0, 0);
    exp_q.push_back(8'hB0);
    cyc(0, 0, 1, 8'h00);
    chk_state("replace_pop", 0, 1, 0, 0, 0);

    // Bypass on empty stack.
    exp_q.push_back(8'h5C);
    cyc(0, 1, 1, 8'h5C);
    chk("bypass.valid", 32'(bus.data_valid), 32'h1);
    chk_state("bypass", 0, 1, 0, 0, 0);

    // Replace top while full: no overflow, count unchanged.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, pv[i]);
    exp_q.push_back(8'h44);
    cyc(0, 1, 1, 8'hEE);
    chk_state("full_replace", 4, 0, 1, 0, 0);
    exp_q.push_back(8'hEE);
    cyc(0, 0, 1, 8'h00);
    exp_q.push_back(8'h33);
    cyc(0, 0, 1, 8'h00);
    chk("full_replace.sp", 32'(bus.sp), 32'h2);
    cyc(1, 0, 0, 8'h00);

    // Asynchronous reset with a pop result in flight.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, pv[i]);
    cyc(0, 0, 1, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("async_rst.valid", 32'(bus.data_valid), 32'h0);
    chk("async_rst.sp",    32'(bus.sp),         32'h0);
    chk("async_rst.empty", 32'(bus.empty),      32'h1);
    @(negedge clk); reset_n = 1'b1;
    cyc(0, 0, 1, 8'h00);
    chk_state("post_rst_pop", 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 8'h00);

`ifdef MPP_STACK_WATERMARK_EN
    cyc(0, 1, 0, 8'h01); cyc(0, 1, 0, 8'h02); cyc(0, 1, 0, 8'h03);
    exp_q.push_back(8'h03); cyc(0, 0, 1, 8'h00);
    exp_q.push_back(8'h02); cyc(0, 0, 1, 8'h00);
    cyc(0, 1, 0, 8'h04);
    chk("watermark.hw", 32'(bus.high_water), 32'h3);
    chk("watermark.sp", 32'(bus.sp),         32'h2);
    cyc(1, 0, 0, 8'h00);
    chk("watermark.clear", 32'(bus.high_water), 32'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
